// File: rtl/dut_step_ctrl.sv
// Host-driven single-step sequencer: decodes AXIS command packets, loads the DUT
// input bus, issues counted clock-enable pulses and returns captured DUT outputs.
module dut_step_ctrl #(
  parameter int C_DATA_WIDTH      = 128,
  parameter int VIP2DUT_WORDS_NUM = 1,
  parameter int DUT2VIP_WORDS_NUM = 1,
  parameter int STEP_GAP          = 2
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      s_axis_tvalid,
  output logic                                      s_axis_tready,
  input  logic [C_DATA_WIDTH-1:0]                   s_axis_tdata,
  input  logic [C_DATA_WIDTH/8-1:0]                 s_axis_tkeep,
  input  logic                                      s_axis_tlast,
  output logic                                      m_axis_tvalid,
  input  logic                                      m_axis_tready,
  output logic [C_DATA_WIDTH-1:0]                   m_axis_tdata,
  output logic [C_DATA_WIDTH/8-1:0]                 m_axis_tkeep,
  output logic                                      m_axis_tlast,
  output logic [C_DATA_WIDTH*VIP2DUT_WORDS_NUM-1:0] vip2dut_bus,
  input  logic [C_DATA_WIDTH*DUT2VIP_WORDS_NUM-1:0] dut2vip_bus,
  output logic                                      dut_ce,
  output logic                                      bad_packet,
  output logic                                      busy,
  output logic [31:0]                               step_total
);

  localparam int VW  = C_DATA_WIDTH * VIP2DUT_WORDS_NUM;
  localparam int DW  = C_DATA_WIDTH * DUT2VIP_WORDS_NUM;
  localparam int KW  = C_DATA_WIDTH / 8;
  localparam int VIW = (VIP2DUT_WORDS_NUM > 1) ? $clog2(VIP2DUT_WORDS_NUM) : 1;
  localparam int DIW = (DUT2VIP_WORDS_NUM > 1) ? $clog2(DUT2VIP_WORDS_NUM) : 1;
  localparam int GW  = (STEP_GAP > 1) ? $clog2(STEP_GAP) : 1;

  localparam logic [VIW-1:0] LOAD_LAST = VIW'(VIP2DUT_WORDS_NUM - 1);
  localparam logic [DIW-1:0] SEND_LAST = DIW'(DUT2VIP_WORDS_NUM - 1);
  localparam logic [GW-1:0]  GAP_INIT  = GW'(STEP_GAP - 1);

  localparam logic [7:0] OP_WRITE     = 8'h01;
  localparam logic [7:0] OP_STEP      = 8'h02;
  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_STEP_READ = 8'h04;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_STEP_HI, S_STEP_GAP, S_CAPTURE, S_SEND, S_DRAIN
  } state_t;

  state_t          state_reg;
  logic            ready_en_reg;
  logic [15:0]     remain_reg;
  logic [GW-1:0]   gap_reg;
  logic            step_read_reg;
  logic [VIW-1:0]  load_idx_reg;
  logic [DIW-1:0]  send_idx_reg;
  logic [VW-1:0]   shadow_reg;
  logic [VW-1:0]   shadow_next;
  logic [DW-1:0]   resp_reg;
  logic [VW-1:0]   vip2dut_reg;
  logic            dut_ce_reg;
  logic            bad_packet_reg;
  logic [31:0]     step_total_reg;

  logic        s_hs;
  logic        m_hs;
  logic [7:0]  hdr_opcode;
  logic [15:0] hdr_count;
  logic        unused_tkeep;

  assign s_hs       = s_axis_tvalid && s_axis_tready;
  assign m_hs       = m_axis_tvalid && m_axis_tready;
  assign hdr_opcode = s_axis_tdata[7:0];
  assign hdr_count  = s_axis_tdata[31:16];
  assign unused_tkeep = ^s_axis_tkeep;

  // Shadow with the incoming word merged in, so the last word commits in one edge.
  genvar gi;
  generate
    for (gi = 0; gi < VIP2DUT_WORDS_NUM; gi++) begin : g_shadow
      assign shadow_next[gi*C_DATA_WIDTH +: C_DATA_WIDTH] =
        (load_idx_reg == VIW'(gi)) ? s_axis_tdata : shadow_reg[gi*C_DATA_WIDTH +: C_DATA_WIDTH];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      ready_en_reg   <= 1'b0;
      remain_reg     <= '0;
      gap_reg        <= '0;
      step_read_reg  <= 1'b0;
      load_idx_reg   <= '0;
      send_idx_reg   <= '0;
      shadow_reg     <= '0;
      resp_reg       <= '0;
      vip2dut_reg    <= '0;
      dut_ce_reg     <= 1'b0;
      bad_packet_reg <= 1'b0;
      step_total_reg <= '0;
    end else begin
      ready_en_reg   <= 1'b1;
      dut_ce_reg     <= 1'b0;
      bad_packet_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (s_hs) begin
            if (hdr_opcode == OP_WRITE && !s_axis_tlast) begin
              load_idx_reg <= '0;
              state_reg    <= S_LOAD;
            end else if ((hdr_opcode == OP_STEP || hdr_opcode == OP_STEP_READ) && s_axis_tlast) begin
              step_read_reg <= (hdr_opcode == OP_STEP_READ);
              remain_reg    <= hdr_count;
              if (hdr_count != 16'd0) begin
                dut_ce_reg <= 1'b1;
                state_reg  <= S_STEP_HI;
              end else if (hdr_opcode == OP_STEP_READ) begin
                state_reg <= S_CAPTURE;
              end
            end else if (hdr_opcode == OP_READ && s_axis_tlast) begin
              state_reg <= S_CAPTURE;
            end else begin
              bad_packet_reg <= 1'b1;
              state_reg      <= s_axis_tlast ? S_IDLE : S_DRAIN;
            end
          end
        end
        S_LOAD: begin
          if (s_hs) begin
            shadow_reg <= shadow_next;
            if (load_idx_reg == LOAD_LAST) begin
              if (s_axis_tlast) begin
                vip2dut_reg <= shadow_next;
                state_reg   <= S_IDLE;
              end else begin
                bad_packet_reg <= 1'b1;
                state_reg      <= S_DRAIN;
              end
            end else if (s_axis_tlast) begin
              bad_packet_reg <= 1'b1;
              state_reg      <= S_IDLE;
            end else begin
              load_idx_reg <= load_idx_reg + VIW'(1);
            end
          end
        end
        S_STEP_HI: begin
          step_total_reg <= step_total_reg + 32'd1;
          remain_reg     <= remain_reg - 16'd1;
          gap_reg        <= GAP_INIT;
          state_reg      <= S_STEP_GAP;
        end
        S_STEP_GAP: begin
          if (gap_reg == '0) begin
            if (remain_reg != 16'd0) begin
              dut_ce_reg <= 1'b1;
              state_reg  <= S_STEP_HI;
            end else begin
              state_reg <= step_read_reg ? S_CAPTURE : S_IDLE;
            end
          end else begin
            gap_reg <= gap_reg - GW'(1);
          end
        end
        S_CAPTURE: begin
          resp_reg     <= dut2vip_bus;
          send_idx_reg <= '0;
          state_reg    <= S_SEND;
        end
        S_SEND: begin
          if (m_hs) begin
            if (send_idx_reg == SEND_LAST) begin
              state_reg <= S_IDLE;
            end else begin
              send_idx_reg <= send_idx_reg + DIW'(1);
            end
          end
        end
        S_DRAIN: begin
          if (s_hs && s_axis_tlast) begin
            state_reg <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign s_axis_tready = ready_en_reg &&
                         (state_reg == S_IDLE || state_reg == S_LOAD || state_reg == S_DRAIN);
  assign m_axis_tvalid = (state_reg == S_SEND);
  assign m_axis_tlast  = (state_reg == S_SEND) && (send_idx_reg == SEND_LAST);
  assign m_axis_tdata  = resp_reg[send_idx_reg*C_DATA_WIDTH +: C_DATA_WIDTH];
  assign m_axis_tkeep  = {KW{m_axis_tvalid}};
  assign vip2dut_bus   = vip2dut_reg;
  assign dut_ce        = dut_ce_reg;
  assign bad_packet    = bad_packet_reg;
  assign busy          = (state_reg != S_IDLE);
  assign step_total    = step_total_reg;

endmodule
